mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 256-bit memory port (read/write/address/writedata/readdata, 1-cycle registered
//  read) between NUM_REQ requesters, e.g. instruction/operand loader and result writeback.
//  Grants whole bursts round-robin, sequences per-beat addresses and write data, and routes
//  returned read data back to the owner. Sits between the compute controllers and the memory model.
// PARAMETERS
//  NUM_REQ  2  number of requesters, legal 2..4
//  LEN_W    6  width of burst length field; max burst (2**LEN_W)-1 words
// PORTS
//  clock         in   1                      single clock, all logic on posedge
//  reset         in   1                      synchronous, active-high
//  req_valid     in   NUM_REQ                burst request, held until req_ready
//  req_write     in   NUM_REQ                1=write burst, 0=read burst
//  req_addr      in   NUM_REQ*ADDR_WIDTH     start word address, slice i = requester i
//  req_len       in   NUM_REQ*LEN_W          beats in burst; 0 treated as 1
//  req_ready     out  NUM_REQ                one-cycle pulse: request accepted
//  wr_data       in   NUM_REQ*DATA_WIDTH*BANDWIDTH  current write beat per requester
//  wr_ready      out  NUM_REQ                beat consumed this cycle; requester advances next cycle
//  rd_data       out  DATA_WIDTH*BANDWIDTH   read beat, broadcast to all
//  rd_valid      out  NUM_REQ                rd_data valid for requester i
//  done          out  NUM_REQ                one-cycle pulse: burst fully complete
//  mem_read      out  1                      to memory read
//  mem_write     out  1                      to memory write
//  mem_address   out  ADDR_WIDTH             to memory address
//  mem_writedata out  DATA_WIDTH*BANDWIDTH   to memory writedata
//  mem_readdata  in   DATA_WIDTH*BANDWIDTH   from memory, valid cycle after mem_read
// BEHAVIOUR
//  - Reset: state IDLE, rr pointer=0, all outputs 0 (req_ready, wr_ready, rd_valid, done, mem_read,
//    mem_write, mem_address, mem_writedata, rd_data). Reset mid-burst aborts it: no done, no further
//    beats; in-flight read data discarded (rd_valid forced 0 the cycle after reset).
//  - FSM: IDLE, RD_BURST, WR_BURST, RD_DRAIN.
//  - IDLE: if any req_valid, pick first set bit scanning from rr pointer upward (wrap mod NUM_REQ);
//    pulse req_ready[owner] that cycle; latch owner, addr, len (0->1), write flag; beat count=0;
//    rr pointer <= owner+1 (mod NUM_REQ); next state RD_BURST or WR_BURST. No req -> stay.
//  - RD_BURST: mem_read=1, mem_address=base+beat (mod 2**ADDR_WIDTH, wraps silently);
//    beat++ each cycle; after last beat issued -> RD_DRAIN.
//  - Read return: rd_valid[owner]=1 exactly the cycle after each mem_read cycle;
//    rd_data=mem_readdata (comb. pass-through), 0 when no rd_valid. Beats in address order, no gaps.
//  - RD_DRAIN: one cycle, last data returns; done[owner]=1 this cycle; -> IDLE.
//  - WR_BURST: mem_write=1, mem_address=base+beat, mem_writedata=wr_data[owner],
//    wr_ready[owner]=1 same cycle (comb.); beat++; on last beat done[owner]=1 same cycle,
//    -> IDLE.
//  - Latency: req_valid seen in IDLE -> first mem op next cycle. Read burst of N: done N+1 cycles
//    after accept; write burst of N: done N cycles after accept. One idle cycle between bursts.
//  - mem_read and mem_write never both 1. Non-owners see req_ready/wr_ready/rd_valid/done = 0.
//  - req_valid dropped before req_ready: no error, simply not granted. req_* of owner ignored
//    after accept (latched). New request from the current owner waits for IDLE like any other.
//  - Outside bursts mem_address and mem_writedata hold 0.
// TESTING
//  1 Reset, req0 read addr=10 len=3 -> req_ready0 cyc0; mem_read addr 10,11,12 cyc1-3;
//    rd_valid0 cyc2-4 with mem words 10,11,12; done0 cyc4.
//  2 req1 write addr=30 len=2 data A,B -> mem_write addr30=A, addr31=B; wr_ready1 2 cycles;
//    done1 on 2nd beat; readback of 30/31 returns A,B.
//  3 req0 and req1 held valid continuously, len=1 -> grants alternate 0,1,0,1; no requester
//    starved; rr pointer after reset favours req0 first.
//  4 req0 read addr=(2**ADDR_WIDTH)-2 len=4 -> addresses max-1, max, 0, 1; 4 rd_valid beats.
//  5 reset asserted during beat 2 of 5-beat read -> next cycle all outputs 0, no done, FSM IDLE;
//    fresh request then serviced normally.
//  6 req_len=0 -> treated as single beat; done after 1 beat (write) / 2 cycles (read).

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the shared
// memory port. The arbiter takes the slave view. Requesters and the memory
// model take the master view.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int LEN_W      = 6,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BANDWIDTH  = 8
);
  localparam int WORD_W = DATA_WIDTH * BANDWIDTH;

  // Requester side. Per-requester fields are packed flat, with slice i belonging to requester i.
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]      req_len;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*WORD_W-1:0]     wr_data;
  logic [NUM_REQ-1:0]            wr_ready;
  logic [WORD_W-1:0]             rd_data;
  logic [NUM_REQ-1:0]            rd_valid;
  logic [NUM_REQ-1:0]            done;

  // Memory side. This is a single port with a one-cycle registered read.
  logic                          mem_read;
  logic                          mem_write;
  logic [ADDR_WIDTH-1:0]         mem_address;
  logic [WORD_W-1:0]             mem_writedata;
  logic [WORD_W-1:0]             mem_readdata;

  modport master (
    output req_valid, req_write, req_addr, req_len, wr_data, mem_readdata,
    input  req_ready, wr_ready, rd_data, rd_valid, done,
           mem_read, mem_write, mem_address, mem_writedata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_data, mem_readdata,
    output req_ready, wr_ready, rd_data, rd_valid, done,
           mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin burst arbiter for one shared 256-bit memory port.
// The arbiter grants a whole burst to one requester and then steps the word
// address once per beat. During write bursts it forwards the owner's write
// data. During read bursts it routes returned read data back to the owner.
module mem_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int LEN_W      = 6,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BANDWIDTH  = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  mem_port_arbiter_if.slave  bus
);
  localparam int WORD_W = DATA_WIDTH * BANDWIDTH;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]     NUM_EXT  = (IDX_W + 1)'(NUM_REQ);
  localparam logic [LEN_W-1:0]   LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]   LEN_TWO  = LEN_W'(2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      rr_q;
  logic [IDX_W-1:0]      owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;      // address of the beat currently on the port
  logic [LEN_W-1:0]      remain_q;    // beats left, including the current one
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [NUM_REQ-1:0]    rd_valid_q;
  logic [NUM_REQ-1:0]    done_q;

  // Per-requester views of the flat request buses.
  logic [ADDR_WIDTH-1:0] req_addr_a [NUM_REQ];
  logic [LEN_W-1:0]      req_len_a  [NUM_REQ];
  logic [WORD_W-1:0]     wr_data_a  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_addr_a[gi] = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign req_len_a[gi]  = bus.req_len[gi*LEN_W +: LEN_W];
      assign wr_data_a[gi]  = bus.wr_data[gi*WORD_W +: WORD_W];
    end
  endgenerate

  logic                  grant_any_d;
  logic [IDX_W-1:0]      grant_idx_d;
  logic [IDX_W:0]        cand_d;
  logic [NUM_REQ-1:0]    grant_oh_d;
  logic [NUM_REQ-1:0]    owner_oh;
  logic [LEN_W-1:0]      len_eff_d;
  logic [IDX_W-1:0]      rr_next_d;
  logic                  accept_d;

  // Find the first valid requester at or above the round-robin pointer.
  // The scan runs from the far end down to the pointer, so the nearest
  // valid requester is the last one assigned and therefore wins.
  always_comb begin
    grant_any_d = 1'b0;
    grant_idx_d = '0;
    cand_d      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand_d = {1'b0, rr_q} + (IDX_W + 1)'(i);
      if (cand_d >= NUM_EXT) begin
        cand_d = cand_d - NUM_EXT;
      end
      if (bus.req_valid[cand_d[IDX_W-1:0]]) begin
        grant_any_d = 1'b1;
        grant_idx_d = cand_d[IDX_W-1:0];
      end
    end
  end

  // Grant bookkeeping: the accept strobe, the normalised length, and the next pointer.
  always_comb begin
    accept_d   = (state_q == IDLE) && grant_any_d && !reset_i;
    grant_oh_d = ONE_HOT0 << grant_idx_d;
    owner_oh   = ONE_HOT0 << owner_q;
    len_eff_d  = (req_len_a[grant_idx_d] == '0) ? LEN_ONE : req_len_a[grant_idx_d];
    rr_next_d  = (grant_idx_d == LAST_IDX) ? '0 : grant_idx_d + IDX_W'(1);
  end

  // Burst sequencer. This block holds the state, the beat address and counter,
  // and the registered strobes that drive the memory port.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      remain_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rd_valid_q  <= '0;
      done_q      <= '0;
    end else begin
      // Read data returns one cycle after each read beat, tagged with the owner.
      rd_valid_q <= mem_read_q ? owner_oh : '0;
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (accept_d) begin
            owner_q  <= grant_idx_d;
            rr_q     <= rr_next_d;
            addr_q   <= req_addr_a[grant_idx_d];
            remain_q <= len_eff_d;
            if (bus.req_write[grant_idx_d]) begin
              state_q     <= WR_BURST;
              mem_write_q <= 1'b1;
              // A single-beat write completes on its only beat.
              done_q      <= (len_eff_d == LEN_ONE) ? grant_oh_d : '0;
            end else begin
              state_q    <= RD_BURST;
              mem_read_q <= 1'b1;
            end
          end
        end
        RD_BURST: begin
          if (remain_q == LEN_ONE) begin
            // Last read issued. Its data comes back during the drain cycle.
            state_q    <= RD_DRAIN;
            mem_read_q <= 1'b0;
            addr_q     <= '0;
            remain_q   <= '0;
            done_q     <= owner_oh;
          end else begin
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            remain_q <= remain_q - LEN_ONE;
          end
        end
        RD_DRAIN: begin
          state_q <= IDLE;
          done_q  <= '0;
        end
        WR_BURST: begin
          if (remain_q == LEN_ONE) begin
            state_q     <= IDLE;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            remain_q    <= '0;
            done_q      <= '0;
          end else begin
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            remain_q <= remain_q - LEN_ONE;
            // Raise done so that it lines up with the final write beat.
            done_q   <= (remain_q == LEN_TWO) ? owner_oh : '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output steering. Write data and rd_data are combinational pass-throughs,
  // and they are forced to zero outside their active cycles.
  always_comb begin
    bus.req_ready     = accept_d ? grant_oh_d : '0;
    bus.wr_ready      = mem_write_q ? owner_oh : '0;
    bus.mem_read      = mem_read_q;
    bus.mem_write     = mem_write_q;
    bus.mem_address   = addr_q;
    bus.mem_writedata = mem_write_q ? wr_data_a[owner_q] : '0;
    bus.rd_valid      = rd_valid_q;
    bus.rd_data       = (|rd_valid_q) ? bus.mem_readdata : '0;
    bus.done          = done_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Each test pushes the events it expects, tagged with absolute cycle
// numbers. A negedge monitor logs the events the DUT actually produces.
// The test then pops both queues and compares them entry by entry.
module tb_mem_port_arbiter;
  localparam int NUM_REQ = 2;
  localparam int LEN_W   = 6;
  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int BW      = 8;
  localparam int WW      = DW * BW;

  localparam int K_RR  = 1;  // req_ready pulse
  localparam int K_MR  = 2;  // memory read beat
  localparam int K_MW  = 3;  // memory write beat
  localparam int K_WR  = 4;  // wr_ready
  localparam int K_RV  = 5;  // rd_valid with data
  localparam int K_DN  = 6;  // done pulse
  localparam int K_BAD = 7;  // protocol violation seen on the bus

  typedef struct packed {
    logic [31:0]   cyc;
    logic [3:0]    kind;
    logic [3:0]    who;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ev_t           exp_q[$];
  ev_t           obs_q[$];
  logic [WW-1:0] wq0[$];
  logic [WW-1:0] wq1[$];
  logic [NUM_REQ-1:0] wr_seen = '0;
  logic [WW-1:0] ref_mem   [256];
  logic [WW-1:0] mem_model [256];
  logic [255:0]  mem_written = '0;

  mem_port_arbiter_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .ADDR_WIDTH(AW),
                        .DATA_WIDTH(DW), .BANDWIDTH(BW)) bus ();

  mem_port_arbiter #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .ADDR_WIDTH(AW),
                     .DATA_WIDTH(DW), .BANDWIDTH(BW)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WW-1:0] init_word(int k);
    logic [7:0] b;
    b = k[7:0];
    return {8{24'hC0FFEE, b}};
  endfunction

  function automatic ev_t mk_ev(int c, int k, int w, int a, logic [WW-1:0] d);
    ev_t e;
    e.cyc  = c;
    e.kind = k[3:0];
    e.who  = w[3:0];
    e.addr = a[AW-1:0];
    e.data = d;
    return e;
  endfunction

  // Memory model with a one-cycle registered read. Unwritten words return their init pattern.
  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem_model[bus.mem_address]   <= bus.mem_writedata;
      mem_written[bus.mem_address] <= 1'b1;
    end
    if (bus.mem_read) begin
      bus.mem_readdata <= mem_written[bus.mem_address] ? mem_model[bus.mem_address]
                                                       : init_word(int'(bus.mem_address));
    end
  end

  // Requester write-data model. Each requester advances to its next word in the cycle after wr_ready.
  always @(posedge clk) begin
    #1;
    if (wr_seen[0] && wq0.size() > 0) void'(wq0.pop_front());
    if (wr_seen[1] && wq1.size() > 0) void'(wq1.pop_front());
    bus.wr_data[WW-1:0]    = (wq0.size() > 0) ? wq0[0] : '0;
    bus.wr_data[2*WW-1:WW] = (wq1.size() > 0) ? wq1[0] : '0;
  end

  // Event monitor. It samples on the falling edge, in a fixed order within each cycle.
  always @(negedge clk) begin
    wr_seen = bus.wr_ready;
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.req_ready[i]) obs_q.push_back(mk_ev(cyc, K_RR, i, 0, '0));
    if (bus.mem_read)  obs_q.push_back(mk_ev(cyc, K_MR, 0, int'(bus.mem_address), '0));
    if (bus.mem_write) obs_q.push_back(mk_ev(cyc, K_MW, 0, int'(bus.mem_address), bus.mem_writedata));
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.wr_ready[i]) obs_q.push_back(mk_ev(cyc, K_WR, i, 0, '0));
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.rd_valid[i]) obs_q.push_back(mk_ev(cyc, K_RV, i, 0, bus.rd_data));
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.done[i]) obs_q.push_back(mk_ev(cyc, K_DN, i, 0, '0));
    if (bus.mem_read && bus.mem_write) obs_q.push_back(mk_ev(cyc, K_BAD, 1, 0, '0));
    if (!bus.mem_read && !bus.mem_write && (bus.mem_address != '0 || bus.mem_writedata != '0))
      obs_q.push_back(mk_ev(cyc, K_BAD, 2, int'(bus.mem_address), bus.mem_writedata));
    if (bus.rd_valid == '0 && bus.rd_data != '0)
      obs_q.push_back(mk_ev(cyc, K_BAD, 3, 0, bus.rd_data));
  end

  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, bit v, bit w, int a, int n);
    bus.req_valid[i]             = v;
    bus.req_write[i]             = w;
    bus.req_addr[i*AW +: AW]     = a[AW-1:0];
    bus.req_len[i*LEN_W +: LEN_W] = n[LEN_W-1:0];
  endtask

  // Expected events for a read burst of n beats accepted in cycle b.
  task automatic exp_read(int w, int a, int n, int b);
    exp_q.push_back(mk_ev(b, K_RR, w, 0, '0));
    for (int c = 1; c <= n + 1; c++) begin
      if (c <= n) exp_q.push_back(mk_ev(b + c, K_MR, 0, (a + c - 1) & 255, '0));
      if (c >= 2) exp_q.push_back(mk_ev(b + c, K_RV, w, 0, ref_mem[(a + c - 2) & 255]));
      if (c == n + 1) exp_q.push_back(mk_ev(b + c, K_DN, w, 0, '0));
    end
  endtask

  // Expected events for a write burst of up to two beats. The reference memory is updated as well.
  task automatic exp_write(int w, int a, int n, int b, logic [WW-1:0] d0, logic [WW-1:0] d1);
    logic [WW-1:0] d;
    exp_q.push_back(mk_ev(b, K_RR, w, 0, '0));
    for (int c = 1; c <= n; c++) begin
      d = (c == 1) ? d0 : d1;
      ref_mem[(a + c - 1) & 255] = d;
      exp_q.push_back(mk_ev(b + c, K_MW, 0, (a + c - 1) & 255, d));
      exp_q.push_back(mk_ev(b + c, K_WR, w, 0, '0));
      if (c == n) exp_q.push_back(mk_ev(b + c, K_DN, w, 0, '0));
    end
  endtask

  task automatic test_reset();
    logic [4*NUM_REQ+1:0] ctrl;
    set_req(0, 1, 0, 5, 1);
    set_req(1, 0, 0, 0, 0);
    wait_cycles(3);
    obs_q.delete();
    wait_cycles(2);
    @(negedge clk);
    ctrl = {bus.req_ready, bus.wr_ready, bus.rd_valid, bus.done, bus.mem_read, bus.mem_write};
    n_cmp++;
    if (ctrl !== '0) begin
      n_bad++; $display("FAIL t0_reset_ctrl: got %b, expected all 0", ctrl);
    end
    n_cmp++;
    if (bus.mem_address !== '0) begin
      n_bad++; $display("FAIL t0_reset_addr: got %0d, expected 0", bus.mem_address);
    end
    n_cmp++;
    if (bus.mem_writedata !== '0 || bus.rd_data !== '0) begin
      n_bad++; $display("FAIL t0_reset_data: got wd=%h rd=%h, expected 0", bus.mem_writedata, bus.rd_data);
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL t0_reset_quiet: got %0d events, expected 0", obs_q.size());
    end
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0);
    rst = 1'b0;
    wait_cycles(2);
    obs_q.delete();
    $display("t0 reset: outputs idle under reset with req0 asserted");
  endtask

  task automatic test_single_read();
    ev_t e, o;
    int b;
    exp_q.delete(); obs_q.delete();
    b = cyc;
    exp_read(0, 10, 3, b);
    set_req(0, 1, 0, 10, 3);
    wait_cycles(1);
    set_req(0, 0, 0, 0, 0);
    wait_cycles(6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL t1_read: missing cyc=%0d kind=%0d who=%0d addr=%0d", e.cyc, e.kind, e.who, e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL t1_read: got cyc=%0d kind=%0d who=%0d addr=%0d data=%h, expected cyc=%0d kind=%0d who=%0d addr=%0d data=%h",
                   o.cyc, o.kind, o.who, o.addr, o.data, e.cyc, e.kind, e.who, e.addr, e.data);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; o = obs_q[0];
      $display("FAIL t1_read_extra: got %0d extra events (first cyc=%0d kind=%0d who=%0d), expected 0", obs_q.size(), o.cyc, o.kind, o.who);
    end
    $display("t1 read: req0 addr=10 len=3 checked");
  endtask

  task automatic test_write_readback();
    ev_t e, o;
    int b;
    logic [WW-1:0] da, db;
    da = {8{32'hAAAA0001}};
    db = {8{32'hBBBB0002}};
    exp_q.delete(); obs_q.delete();
    wq1.push_back(da);
    wq1.push_back(db);
    b = cyc;
    exp_write(1, 30, 2, b, da, db);
    set_req(1, 1, 1, 30, 2);
    wait_cycles(1);
    set_req(1, 0, 0, 0, 0);
    wait_cycles(4);
    b = cyc;
    exp_read(1, 30, 2, b);
    set_req(1, 1, 0, 30, 2);
    wait_cycles(1);
    set_req(1, 0, 0, 0, 0);
    wait_cycles(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL t2_write: missing cyc=%0d kind=%0d who=%0d addr=%0d", e.cyc, e.kind, e.who, e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL t2_write: got cyc=%0d kind=%0d who=%0d addr=%0d data=%h, expected cyc=%0d kind=%0d who=%0d addr=%0d data=%h",
                   o.cyc, o.kind, o.who, o.addr, o.data, e.cyc, e.kind, e.who, e.addr, e.data);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; o = obs_q[0];
      $display("FAIL t2_write_extra: got %0d extra events (first cyc=%0d kind=%0d who=%0d), expected 0", obs_q.size(), o.cyc, o.kind, o.who);
    end
    $display("t2 write: req1 addr=30 len=2 then readback checked");
  endtask

  task automatic test_round_robin();
    ev_t e, o;
    int b;
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    exp_q.delete(); obs_q.delete();
    b = cyc;
    exp_read(0, 40, 1, b);
    exp_read(1, 50, 1, b + 3);
    exp_read(0, 40, 1, b + 6);
    exp_read(1, 50, 1, b + 9);
    set_req(0, 1, 0, 40, 1);
    set_req(1, 1, 0, 50, 1);
    wait_cycles(10);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    wait_cycles(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL t3_rr: missing cyc=%0d kind=%0d who=%0d addr=%0d", e.cyc, e.kind, e.who, e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL t3_rr: got cyc=%0d kind=%0d who=%0d addr=%0d data=%h, expected cyc=%0d kind=%0d who=%0d addr=%0d data=%h",
                   o.cyc, o.kind, o.who, o.addr, o.data, e.cyc, e.kind, e.who, e.addr, e.data);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; o = obs_q[0];
      $display("FAIL t3_rr_extra: got %0d extra events (first cyc=%0d kind=%0d who=%0d), expected 0", obs_q.size(), o.cyc, o.kind, o.who);
    end
    $display("t3 round robin: grants 0,1,0,1 checked");
  endtask

  task automatic test_addr_wrap();
    ev_t e, o;
    int b;
    exp_q.delete(); obs_q.delete();
    b = cyc;
    exp_read(0, 254, 4, b);
    set_req(0, 1, 0, 254, 4);
    wait_cycles(1);
    set_req(0, 0, 0, 0, 0);
    wait_cycles(7);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL t4_wrap: missing cyc=%0d kind=%0d who=%0d addr=%0d", e.cyc, e.kind, e.who, e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL t4_wrap: got cyc=%0d kind=%0d who=%0d addr=%0d data=%h, expected cyc=%0d kind=%0d who=%0d addr=%0d data=%h",
                   o.cyc, o.kind, o.who, o.addr, o.data, e.cyc, e.kind, e.who, e.addr, e.data);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; o = obs_q[0];
      $display("FAIL t4_wrap_extra: got %0d extra events (first cyc=%0d kind=%0d who=%0d), expected 0", obs_q.size(), o.cyc, o.kind, o.who);
    end
    $display("t4 wrap: req0 addr=254 len=4 checked");
  endtask

  task automatic test_reset_abort();
    ev_t e, o;
    int b;
    logic [4*NUM_REQ+1:0] ctrl;
    exp_q.delete(); obs_q.delete();
    b = cyc;
    exp_q.push_back(mk_ev(b,     K_RR, 0, 0,   '0));
    exp_q.push_back(mk_ev(b + 1, K_MR, 0, 100, '0));
    exp_q.push_back(mk_ev(b + 2, K_MR, 0, 101, '0));
    exp_q.push_back(mk_ev(b + 2, K_RV, 0, 0,   ref_mem[100]));
    set_req(0, 1, 0, 100, 5);
    wait_cycles(1);
    set_req(0, 0, 0, 0, 0);
    wait_cycles(1);
    rst = 1'b1;
    wait_cycles(1);
    @(negedge clk);
    ctrl = {bus.req_ready, bus.wr_ready, bus.rd_valid, bus.done, bus.mem_read, bus.mem_write};
    n_cmp++;
    if (ctrl !== '0) begin
      n_bad++; $display("FAIL t5_abort_ctrl: got %b, expected all 0", ctrl);
    end
    n_cmp++;
    if (bus.mem_address !== '0 || bus.rd_data !== '0) begin
      n_bad++; $display("FAIL t5_abort_bus: got addr=%0d rd=%h, expected 0", bus.mem_address, bus.rd_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cycles(3);
    b = cyc;
    exp_read(0, 7, 2, b);
    set_req(0, 1, 0, 7, 2);
    wait_cycles(1);
    set_req(0, 0, 0, 0, 0);
    wait_cycles(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL t5_abort: missing cyc=%0d kind=%0d who=%0d addr=%0d", e.cyc, e.kind, e.who, e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL t5_abort: got cyc=%0d kind=%0d who=%0d addr=%0d data=%h, expected cyc=%0d kind=%0d who=%0d addr=%0d data=%h",
                   o.cyc, o.kind, o.who, o.addr, o.data, e.cyc, e.kind, e.who, e.addr, e.data);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; o = obs_q[0];
      $display("FAIL t5_abort_extra: got %0d extra events (first cyc=%0d kind=%0d who=%0d), expected 0", obs_q.size(), o.cyc, o.kind, o.who);
    end
    $display("t5 reset abort: 5-beat read cut at beat 2, fresh read serviced");
  endtask

  task automatic test_len_zero();
    ev_t e, o;
    int b;
    logic [WW-1:0] dc;
    dc = {8{32'h5EED00CC}};
    exp_q.delete(); obs_q.delete();
    wq1.push_back(dc);
    b = cyc;
    exp_write(1, 200, 1, b, dc, '0);
    set_req(1, 1, 1, 200, 0);
    wait_cycles(1);
    set_req(1, 0, 0, 0, 0);
    wait_cycles(3);
    b = cyc;
    exp_read(0, 200, 1, b);
    set_req(0, 1, 0, 200, 0);
    wait_cycles(1);
    set_req(0, 0, 0, 0, 0);
    wait_cycles(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL t6_len0: missing cyc=%0d kind=%0d who=%0d addr=%0d", e.cyc, e.kind, e.who, e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL t6_len0: got cyc=%0d kind=%0d who=%0d addr=%0d data=%h, expected cyc=%0d kind=%0d who=%0d addr=%0d data=%h",
                   o.cyc, o.kind, o.who, o.addr, o.data, e.cyc, e.kind, e.who, e.addr, e.data);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; o = obs_q[0];
      $display("FAIL t6_len0_extra: got %0d extra events (first cyc=%0d kind=%0d who=%0d), expected 0", obs_q.size(), o.cyc, o.kind, o.who);
    end
    $display("t6 len=0: single-beat write and read checked");
  endtask

  initial begin
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    test_reset();
    test_single_read();
    test_write_readback();
    test_round_robin();
    test_addr_wrap();
    test_reset_abort();
    test_len_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
